// File: rtl/des_sbox_serial_f.sv
// des_sbox_serial_f: serial substitution front end of the DES round function.
//   E-expands R, XORs the subkey, then feeds the eight 6-bit chunks (chunk 1 first)
//   through one shared S1 box, one chunk per cycle, packing nibbles into f_out.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + r_in[31:0], subkey_in[47:0];
//   out_valid/out_ready + f_out[31:0]; busy = not idle.
// Latency: accept at edge t -> out_valid after edge t+8 (SBOX_PIPE=0) or t+9 (SBOX_PIPE=1).
module des_sbox_serial_f #(
  parameter int SBOX_PIPE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SUB   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // S1 rows, column 0 in the top nibble.
  localparam logic [63:0] S1_ROW [4] = '{
    64'hE4D12FB83A6C5907,
    64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50,
    64'hFC8249175B3EA06D
  };

  logic [1:0]  state;
  logic [47:0] x;
  logic [2:0]  cnt;
  logic [31:0] acc;
  logic [31:0] f_q;
  logic [3:0]  nib_q;

  logic [47:0] e_x;
  logic [33:0] ext;
  logic [5:0]  sbox_in;
  logic [63:0] sbox_row;
  logic [5:0]  sbox_sh;
  logic [3:0]  sbox_out;
  logic [3:0]  nib;
  logic        capture;
  logic        last;
  logic [31:0] acc_next;

  // E expansion: ext[33-d] is DES bit d, with bit 0 = bit 32 and bit 33 = bit 1,
  // so chunk k is simply a 6-bit window stepping by 4 through ext.
  always_comb begin
    ext = {r_in[0], r_in, r_in[31]};
    e_x = '0;
    for (int k = 0; k < 8; k++) begin
      e_x[47-6*k -: 6] = ext[33-4*k -: 6];
    end
  end

  // S-box: row from the outer bits, column from the inner four.
  always_comb begin
    sbox_in  = x[47:42];
    sbox_row = S1_ROW[{sbox_in[5], sbox_in[0]}];
    sbox_sh  = {~sbox_in[4:1], 2'b00};
    sbox_out = sbox_row[sbox_sh +: 4];
  end

  // With the pipe register the first SUB cycle has nothing registered yet, and the
  // eighth nibble arrives during FLUSH.
  always_comb begin
    nib      = (SBOX_PIPE != 0) ? nib_q : sbox_out;
    capture  = ((state == SUB) && ((SBOX_PIPE == 0) || (cnt != 3'd0))) || (state == FLUSH);
    last     = (SBOX_PIPE != 0) ? (state == FLUSH) : ((state == SUB) && (cnt == 3'd7));
    acc_next = {acc[27:0], nib};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      cnt   <= '0;
      acc   <= '0;
      f_q   <= '0;
      nib_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= e_x ^ subkey_in;
            cnt   <= 3'd0;
            state <= SUB;
          end
        end
        SUB: begin
          x     <= {x[41:0], 6'b0};
          cnt   <= cnt + 3'd1;
          nib_q <= sbox_out;
          if (cnt == 3'd7) begin
            state <= (SBOX_PIPE != 0) ? FLUSH : DONE;
          end
        end
        FLUSH: begin
          state <= DONE;
        end
        default: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
      endcase

      if (capture) begin
        acc <= acc_next;
      end
      // f_out gets its own register so it only changes when a result completes.
      if (last) begin
        f_q <= acc_next;
      end
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign f_out     = f_q;
  assign busy      = (state != IDLE);

endmodule
